s3ga_cfg_ctrl: RTL
==================

Name: s3ga_cfg_ctrl

Overview:
Configuration and context sequencer for one x64 cluster tree.
- Accepts a CFG_W-wide bitstream over a valid/ready stream and drives the cluster's rst, grst, cfg and cfg_i pins.
- Waits for the cluster's cfgd, then releases grst and runs the M-context cycle counter m.
- Sits between the SoC-side loader (DMA/wishbone shim) and the x64 root cluster.

Parameters:
- M, 4, contexts per cycle; c_m counts 0..M-1.
- CFG_W, 5, config word width; matches the cluster's cfg_i.
- RST_CYCLES, 4, cycles the cluster is held in rst+grst before loading (>=1).
- TIMEOUT, 1024, max cycles in SETTLE waiting for cfgd (>=1).
- MAX_WORDS, 4096, max bitstream beats before a missing bs_last is flagged (>=1).
- M_W, $clog2(M) (min 1), width of c_m.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, pulse: begin (re)configuration.
- bs_valid, in, 1, bitstream beat valid.
- bs_data, in, CFG_W, bitstream beat.
- bs_last, in, 1, final beat of bitstream.
- bs_ready, out, 1, beat accepted when bs_valid&bs_ready.
- busy, out, 1, in RESET/LOAD/SETTLE.
- done, out, 1, cluster configured and running.
- err, out, 1, sticky error; cleared by start.
- c_rst, out, 1, cluster sync reset.
- c_grst, out, 1, cluster "configuration in progress".
- c_m, out, M_W, cycle % M.
- c_cfg, out, 1, cluster config enable.
- c_cfg_i, out, CFG_W, cluster config data.
- c_cfgd, in, 1, cluster reports configured.

Behaviour:
- Clocking and reset: one clock, clk. rst_n is asynchronous and active-low.
- All outputs are registered. Reset values:
  - state=IDLE.
  - c_rst=1, c_grst=1, c_cfg=0, c_cfg_i=0, c_m=0.
  - bs_ready=0, busy=0, done=0, err=0.
  - Word and timer counters = 0.
- Asserting rst_n low mid-operation aborts immediately to the reset values. Any partial bitstream is discarded.
- IDLE: cluster held in c_rst=1, c_grst=1. start -> RESET.
- RESET:
  - c_rst=1, c_grst=1, busy=1, err<=0, done<=0.
  - Hold exactly RST_CYCLES cycles, then -> LOAD.
- LOAD:
  - c_rst=0, c_grst=1, bs_ready=1.
  - On an accepted beat, in the next cycle c_cfg=1 and c_cfg_i=bs_data (1-cycle latency). With no beat accepted, c_cfg=0 and c_cfg_i holds its value.
  - Word count increments per accepted beat.
  - Accepted beat with bs_last=1 -> SETTLE; bs_ready drops in the same edge.
  - Accepted beat number MAX_WORDS without bs_last -> ERROR.
  - c_cfgd=1 while in LOAD (premature) -> ERROR.
- SETTLE:
  - bs_ready=0, c_cfg=0, c_grst=1.
  - Timer counts cycles. c_cfgd=1 -> RUN.
  - Timer reaching TIMEOUT with c_cfgd still 0 -> ERROR.
  - If c_cfgd=1 and the timer expires in the same cycle, c_cfgd wins.
- RUN:
  - c_grst=0, c_rst=0, done=1, busy=0.
  - c_cfgd falling -> ERROR.
  - start -> RESET (reconfigure).
- ERROR:
  - c_grst=1, c_rst=1, bs_ready=0, done=0, err=1.
  - start -> RESET.
- start while busy (RESET/LOAD/SETTLE) is ignored.
- c_m:
  - Increments every cycle and wraps M-1 -> 0.
  - Forced to 0 on the cycle entering LOAD and the cycle entering RUN, so context 0 aligns with the first config word and the first run cycle.
  - M=1: c_m is constant 0.
- Counters are sized $clog2(max+1) and do not overflow.

Decomposition:
- Shared package s3ga_pkg holds:
  - State enum: IDLE, RESET, LOAD, SETTLE, RUN, ERROR.
  - Default constants for RST_CYCLES, TIMEOUT and MAX_WORDS.
- One natural sub-module, s3ga_ctx_ctr: the mod-M counter with sync "align" input. It is reusable by the cluster-tree top.

Test Plan:
- Reset, then start, then 3 beats 0x01, 0x1F, 0x0A (last on 3rd) with c_cfgd raised 2 cycles later:
  - c_cfg high 3 cycles carrying 01, 1F, 0A.
  - done=1, c_grst=0, c_m=0 on the first RUN cycle, then 1,2,3,0.
- bs_valid toggling 1,0,1,0 during LOAD -> c_cfg pulses only after accepted beats; word count=2 after 4 cycles.
- Never raise c_cfgd after last beat (TIMEOUT=16) -> err=1 exactly 16 cycles into SETTLE; c_grst=1, c_rst=1.
- MAX_WORDS=8, 8 beats without bs_last -> ERROR after the 8th beat; bs_ready=0 the next cycle.
- rst_n low during LOAD -> asynchronously returns to the reset values (c_cfg=0, bs_ready=0, c_m=0); a later start reloads cleanly.
- In RUN, drop c_cfgd -> ERROR. Then start -> RESET for RST_CYCLES cycles and err cleared. Also check start in SETTLE is ignored.

Source files
------------

// File: rtl/s3ga_pkg.sv
// ---------------------------------------------------------------------------
// s3ga_pkg
// Shared types and defaults for the x64 cluster configuration sequencer.
//   state_t     : sequencer states (IDLE, RESET, LOAD, SETTLE, RUN, ERROR)
//   DEF_*       : default parameter values for the sequencer and its pieces
//   cnt_w()     : width of a counter that must hold 0..max_val inclusive
//   ctx_w()     : width of the context counter for M contexts (minimum 1)
// ---------------------------------------------------------------------------
package s3ga_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RESET  = 3'd1,
        LOAD   = 3'd2,
        SETTLE = 3'd3,
        RUN    = 3'd4,
        ERROR  = 3'd5
    } state_t;

    localparam int DEF_M          = 4;
    localparam int DEF_CFG_W      = 5;
    localparam int DEF_RST_CYCLES = 4;
    localparam int DEF_TIMEOUT    = 1024;
    localparam int DEF_MAX_WORDS  = 4096;

    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int ctx_w(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/s3ga_cfg_ctrl_if.sv
// ---------------------------------------------------------------------------
// s3ga_cfg_ctrl_if
// Bitstream stream between the SoC-side loader and the configuration
// sequencer. A beat transfers on a clock edge where bs_valid & bs_ready.
//   bs_valid : loader has a beat on bs_data
//   bs_data  : CFG_W-bit configuration word
//   bs_last  : this beat is the final word of the bitstream
//   bs_ready : sequencer accepts a beat this cycle
// Modports: master = loader side, slave = sequencer side.
// ---------------------------------------------------------------------------
interface s3ga_cfg_ctrl_if
    import s3ga_pkg::*;
#(
    parameter int CFG_W = DEF_CFG_W
);

    logic             bs_valid;
    logic [CFG_W-1:0] bs_data;
    logic             bs_last;
    logic             bs_ready;

    modport master (
        output bs_valid,
        output bs_data,
        output bs_last,
        input  bs_ready
    );

    modport slave (
        input  bs_valid,
        input  bs_data,
        input  bs_last,
        output bs_ready
    );

endinterface

// File: rtl/s3ga_ctx_ctr.sv
// ---------------------------------------------------------------------------
// s3ga_ctx_ctr
// Free-running modulo-M context counter with a synchronous align input.
// Reusable by the cluster-tree top to drive each cluster's m pins.
//   clk   : clock
//   rst_n : asynchronous active-low reset (m -> 0)
//   align : force m to 0 on the next edge
//   m     : current context, counts 0..M-1 and wraps; constant 0 when M=1
// ---------------------------------------------------------------------------
module s3ga_ctx_ctr
    import s3ga_pkg::*;
#(
    parameter int M   = DEF_M,
    parameter int M_W = ctx_w(M)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           align,
    output logic [M_W-1:0] m
);

    localparam logic [M_W-1:0] LAST = M_W'(M - 1);

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m <= '0;
        end else if (align || m == LAST) begin
            m <= '0;
        end else begin
            m <= m + M_W'(1);
        end
    end

endmodule

// File: rtl/s3ga_cfg_ctrl.sv
// ---------------------------------------------------------------------------
// s3ga_cfg_ctrl
// Configuration and context sequencer for one x64 cluster tree. Loads a
// CFG_W-wide bitstream into the root cluster, waits for the cluster to report
// cfgd, then releases grst and runs the M-context counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : pulse, begin (re)configuration; ignored while busy
//   bs         : bitstream stream (slave side)
//   busy       : in RESET, LOAD or SETTLE
//   done       : cluster configured and running
//   err        : sticky error, cleared when a new configuration starts
//   c_rst      : cluster synchronous reset
//   c_grst     : cluster "configuration in progress"
//   c_m        : context number, cycle % M
//   c_cfg      : cluster config enable, one cycle after each accepted beat
//   c_cfg_i    : cluster config data, holds between beats
//   c_cfgd     : cluster reports configured
// All outputs are registered: the next-cycle values are decoded from the
// next state so each output flop lines up with the state register.
// ---------------------------------------------------------------------------
module s3ga_cfg_ctrl
    import s3ga_pkg::*;
#(
    parameter int M          = DEF_M,
    parameter int CFG_W      = DEF_CFG_W,
    parameter int RST_CYCLES = DEF_RST_CYCLES,
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter int MAX_WORDS  = DEF_MAX_WORDS,
    parameter int M_W        = ctx_w(M)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    s3ga_cfg_ctrl_if.slave   bs,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             c_rst,
    output logic             c_grst,
    output logic [M_W-1:0]   c_m,
    output logic             c_cfg,
    output logic [CFG_W-1:0] c_cfg_i,
    input  logic             c_cfgd
);

    // One timer serves both the RESET hold and the SETTLE timeout; the two
    // never run at the same time.
    localparam int TMR_MAX = (RST_CYCLES > TIMEOUT) ? RST_CYCLES : TIMEOUT;
    localparam int TMR_W   = cnt_w(TMR_MAX);
    localparam int WC_W    = cnt_w(MAX_WORDS);

    localparam logic [TMR_W-1:0] RST_LAST  = TMR_W'(RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMO_LAST  = TMR_W'(TIMEOUT - 1);
    localparam logic [WC_W-1:0]  WORD_LAST = WC_W'(MAX_WORDS - 1);

    state_t           state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [WC_W-1:0]  wcnt_q, wcnt_d;
    logic             bs_ready_q;

    logic             ready_d, busy_d, done_d, err_d;
    logic             rst_d, grst_d, cfg_d;
    logic [CFG_W-1:0] cfg_i_d;

    logic             accept;
    logic             align;

    assign bs.bs_ready = bs_ready_q;

    // bs_ready_q is only ever high while in LOAD, so it alone qualifies a beat.
    assign accept = bs_ready_q && bs.bs_valid;

    // Context 0 coincides with the first LOAD cycle and the first RUN cycle.
    assign align = (state_d != state_q) && (state_d == LOAD || state_d == RUN);

    // -----------------------------------------------------------------------
    // Next-state and next-output decode
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no branch
        // of the case statements can leave one unassigned and infer a latch.
        state_d = state_q;
        tmr_d   = tmr_q;
        wcnt_d  = wcnt_q;
        cfg_d   = accept;
        cfg_i_d = accept ? bs.bs_data : c_cfg_i;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RESET;
                    tmr_d   = '0;
                end
            end

            RESET: begin
                if (tmr_q == RST_LAST) begin
                    state_d = LOAD;
                    tmr_d   = '0;
                    wcnt_d  = '0;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end

            LOAD: begin
                if (accept) begin
                    wcnt_d = wcnt_q + WC_W'(1);
                end
                // A cluster claiming to be configured before the bitstream
                // has ended cannot be trusted.
                if (c_cfgd) begin
                    state_d = ERROR;
                end else if (accept && bs.bs_last) begin
                    state_d = SETTLE;
                    tmr_d   = '0;
                end else if (accept && wcnt_q == WORD_LAST) begin
                    state_d = ERROR;
                end
            end

            SETTLE: begin
                // cfgd is tested first so it wins over a timer expiring in
                // the same cycle.
                if (c_cfgd) begin
                    state_d = RUN;
                end else if (tmr_q == TMO_LAST) begin
                    state_d = ERROR;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end

            RUN: begin
                // A reconfiguration request takes priority over cfgd dropping.
                if (start) begin
                    state_d = RESET;
                    tmr_d   = '0;
                end else if (!c_cfgd) begin
                    state_d = ERROR;
                end
            end

            ERROR: begin
                if (start) begin
                    state_d = RESET;
                    tmr_d   = '0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        rst_d   = 1'b1;
        grst_d  = 1'b1;
        ready_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = err;

        case (state_d)
            RESET: begin
                busy_d = 1'b1;
                err_d  = 1'b0;
            end
            LOAD: begin
                rst_d   = 1'b0;
                ready_d = 1'b1;
                busy_d  = 1'b1;
            end
            SETTLE: begin
                rst_d  = 1'b0;
                busy_d = 1'b1;
            end
            RUN: begin
                rst_d  = 1'b0;
                grst_d = 1'b0;
                done_d = 1'b1;
            end
            ERROR: begin
                err_d = 1'b1;
            end
            default: begin
                // IDLE: cluster held in reset, err keeps its value.
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tmr_q      <= '0;
            wcnt_q     <= '0;
            bs_ready_q <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            c_rst      <= 1'b1;
            c_grst     <= 1'b1;
            c_cfg      <= 1'b0;
            c_cfg_i    <= '0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            wcnt_q     <= wcnt_d;
            bs_ready_q <= ready_d;
            busy       <= busy_d;
            done       <= done_d;
            err        <= err_d;
            c_rst      <= rst_d;
            c_grst     <= grst_d;
            c_cfg      <= cfg_d;
            c_cfg_i    <= cfg_i_d;
        end
    end

    s3ga_ctx_ctr #(
        .M   (M),
        .M_W (M_W)
    ) u_ctx_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .align (align),
        .m     (c_m)
    );

endmodule
